multi_cycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks instead of decoding one opcode per cycle. Sits between the instruction register and the shared-memory multi-cycle datapath. Adds a ready/wait handshake to the unified memory, a watchdog timeout and a sticky fault state.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/imm_alu_decode.sv | 37 +++
 rtl/multi_cycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared constants for the multi-cycle MIPS control unit:
//             instruction opcodes, ALU control codes and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // ALU control codes
  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_ADDU = 4'b1000;
  localparam logic [3:0] c_ALU_XOR  = 4'b1010;
  localparam logic [3:0] c_ALU_SLTU = 4'b1011;
  localparam logic [3:0] c_ALU_LUI  = 4'b1110;
  localparam logic [3:0] c_ALU_FUNC = 4'b1111;

  // FSM state encoding (visible on the State debug port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXEC = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  // True for the I-type ALU opcodes handled by IEXEC/IWB
  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == c_OP_ADDI)  || (op == c_OP_ADDIU) || (op == c_OP_SLTI) ||
           (op == c_OP_SLTIU) || (op == c_OP_ANDI)  || (op == c_OP_ORI)  ||
           (op == c_OP_XORI)  || (op == c_OP_LUI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_alu_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imm_alu_decode
//  Purpose  : Combinational map from an immediate-class opcode to the ALU
//             control code and the immediate extension mode.
//  Ports    : opcode_i   - instruction opcode
//             alu_op_o   - ALU control code
//             sign_ext_o - 1 sign-extends the immediate, 0 zero-extends
//  Revision : 1.0  initial release
// ============================================================================
module imm_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [3:0] alu_op_o,
  output logic       sign_ext_o
);

  always_comb begin
    alu_op_o   = c_ALU_ADD;
    sign_ext_o = 1'b0;
    case (opcode_i)
      c_OP_ADDI:  begin alu_op_o = c_ALU_ADD;  sign_ext_o = 1'b1; end
      c_OP_ADDIU: begin alu_op_o = c_ALU_ADDU; sign_ext_o = 1'b0; end
      c_OP_ANDI:  begin alu_op_o = c_ALU_AND;  sign_ext_o = 1'b0; end
      c_OP_ORI:   begin alu_op_o = c_ALU_OR;   sign_ext_o = 1'b0; end
      c_OP_XORI:  begin alu_op_o = c_ALU_XOR;  sign_ext_o = 1'b0; end
      c_OP_LUI:   begin alu_op_o = c_ALU_LUI;  sign_ext_o = 1'b0; end
      c_OP_SLTI:  begin alu_op_o = c_ALU_SLT;  sign_ext_o = 1'b1; end
      c_OP_SLTIU: begin alu_op_o = c_ALU_SLTU; sign_ext_o = 1'b0; end
      default:    ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_control
//  Purpose  : Moore control FSM for a shared-memory multi-cycle MIPS datapath.
//             Sequences fetch/decode/execute/memory/write-back, waits on a
//             memory ready handshake with a watchdog, and latches a sticky
//             fault state that only reset clears.
//  Ports    : CLK, Reset_L (async, active low)
//             Opcode, Zero, MemReady                    - inputs
//             PCWriteEn, IorD, MemRead, MemWrite, IRWrite,
//             RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB,
//             PCSource, SignExtend, ALUOp               - datapath controls
//             Fault, State                              - status / debug
//  Revision : 1.0  initial release
// ============================================================================
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWriteEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       SignExtend,
  output logic [3:0] ALUOp,
  output logic       Fault,
  output logic [3:0] State
);

  // Keep the counter at least one bit wide so tiny/zero timeouts still build.
  localparam int            CW          = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit            c_WDOG_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] c_CNT_LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_mem_wait_state;
  logic          w_timeout;
  logic [3:0]    w_imm_alu_op;
  logic          w_imm_sign_ext;

  imm_alu_decode u_imm_alu_decode (
    .opcode_i   (Opcode),
    .alu_op_o   (w_imm_alu_op),
    .sign_ext_o (w_imm_sign_ext)
  );

  // States that wait on the memory handshake and are watched by the watchdog
  assign w_mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                            (state_q == S_MEMWR);
  // Ready on the last allowed cycle wins over the timeout.
  assign w_timeout = c_WDOG_EN && w_mem_wait_state && !MemReady &&
                     (cnt_q == c_CNT_LIMIT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode == c_OP_RTYPE)                         state_d = S_RTEXEC;
        else if ((Opcode == c_OP_LW) || (Opcode == c_OP_SW)) state_d = S_MEMADR;
        else if (Opcode == c_OP_BEQ)                      state_d = S_BRANCH;
        else if ((Opcode == c_OP_BNE) && SUPPORT_BNE)     state_d = S_BRANCH;
        else if (Opcode == c_OP_J)                        state_d = S_JUMP;
        else if (is_imm_op(Opcode))                       state_d = S_IEXEC;
        else                                              state_d = S_FAULT;
      end
      S_MEMADR: begin
        if (Opcode == c_OP_LW)      state_d = S_MEMRD;
        else if (Opcode == c_OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FAULT;
      end
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (w_timeout) state_d = S_FAULT;
  end

  // Wait counter restarts on every state change so each memory state gets
  // its own full timeout budget.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (w_mem_wait_state && !MemReady)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs (plus MemReady/Zero qualified strobes). Reset forces every
  // control to 0 without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    PCWriteEn  = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    SignExtend = 1'b0;
    ALUOp      = c_ALU_AND;
    Fault      = 1'b0;
    State      = state_q;
    if (Reset_L) begin
      case (state_q)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = 2'b01;
          ALUOp     = c_ALU_ADD;
          IRWrite   = MemReady;
          PCWriteEn = MemReady;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUOp      = c_ALU_ADD;
          SignExtend = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUOp      = c_ALU_ADD;
          SignExtend = 1'b1;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTEXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = c_ALU_FUNC;
        end
        S_RTWB: begin
          ALUOp    = c_ALU_FUNC;
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA   = 1'b1;
          ALUOp     = c_ALU_SUB;
          PCSource  = 2'b01;
          PCWriteEn = (SUPPORT_BNE && (Opcode == c_OP_BNE)) ? ~Zero : Zero;
        end
        S_JUMP: begin
          PCSource  = 2'b10;
          PCWriteEn = 1'b1;
        end
        S_IEXEC, S_IWB: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUOp      = w_imm_alu_op;
          SignExtend = w_imm_sign_ext;
          RegWrite   = (state_q == S_IWB);
        end
        S_FAULT: Fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_control
//  Purpose  : Self-checking bench. Each instruction is expanded into the list
//             of states it must visit (from its class and the memory wait
//             counts chosen), and each visited cycle's outputs are derived
//             from that state's control table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_cycle_control;

  localparam int T = 4;   // watchdog limit used by the DUT instance

  typedef struct packed { logic [3:0] st; logic mr; } ent_t;
  typedef ent_t ent_q_t[$];

  logic       CLK = 1'b0;
  logic       Reset_L = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg;
  logic       RegWrite, ALUSrcA, SignExtend, Fault;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  multi_cycle_control #(.MEM_TIMEOUT(T), .SUPPORT_BNE(1'b1)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWriteEn(PCWriteEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .SignExtend(SignExtend), .ALUOp(ALUOp), .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  // Output vector layout:
  // [22]PCWriteEn [21]IorD [20]MemRead [19]MemWrite [18]IRWrite [17]RegDst
  // [16]MemToReg [15]RegWrite [14]ALUSrcA [13:12]ALUSrcB [11:10]PCSource
  // [9]SignExtend [8:5]ALUOp [4]Fault [3:0]State
  logic [22:0] dut_vec;
  assign dut_vec = {PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
                    MemToReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                    SignExtend, ALUOp, Fault, State};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] exp_vec  = '0;
  logic [22:0] exp_mask = '0;
  logic [22:0] rst_mask = '0;
  bit          chk_en = 1'b0;
  bit          rec_en = 1'b0;
  logic [22:0] obs[$];

  // ---------------- reference model ----------------
  function automatic logic [4:0] imm_exp(input logic [5:0] op); // {ALUOp, SignExtend}
    case (op)
      6'h08:   return {4'b0010, 1'b1};  // ADDI
      6'h09:   return {4'b1000, 1'b0};  // ADDIU
      6'h0A:   return {4'b0111, 1'b1};  // SLTI
      6'h0B:   return {4'b1011, 1'b0};  // SLTIU
      6'h0C:   return {4'b0000, 1'b0};  // ANDI
      6'h0D:   return {4'b0001, 1'b0};  // ORI
      6'h0E:   return {4'b1010, 1'b0};  // XORI
      6'h0F:   return {4'b1110, 1'b0};  // LUI
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic [22:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic z, input logic mr);
    logic [22:0] v;
    v = '0;
    v[3:0] = st;
    case (st)
      4'd0:  begin v[20] = 1'b1; v[13:12] = 2'b01; v[8:5] = 4'b0010; v[18] = mr; v[22] = mr; end
      4'd1:  begin v[13:12] = 2'b11; v[8:5] = 4'b0010; v[9] = 1'b1; end
      4'd2:  begin v[14] = 1'b1; v[13:12] = 2'b10; v[8:5] = 4'b0010; v[9] = 1'b1; end
      4'd3:  begin v[20] = 1'b1; v[21] = 1'b1; end
      4'd4:  begin v[15] = 1'b1; v[16] = 1'b1; end
      4'd5:  begin v[19] = 1'b1; v[21] = 1'b1; end
      4'd6:  begin v[14] = 1'b1; v[8:5] = 4'b1111; end
      4'd7:  begin v[8:5] = 4'b1111; v[17] = 1'b1; v[15] = 1'b1; end
      4'd8:  begin v[14] = 1'b1; v[8:5] = 4'b0110; v[11:10] = 2'b01;
                   v[22] = (op == 6'h05) ? ~z : z; end
      4'd9:  begin v[11:10] = 2'b10; v[22] = 1'b1; end
      4'd10, 4'd11: begin
        v[14] = 1'b1; v[13:12] = 2'b10; {v[8:5], v[9]} = imm_exp(op);
        v[15] = (st == 4'd11);
      end
      4'd12: v[4] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic ent_t mk(input logic [3:0] st, input logic mr);
    ent_t e;
    e.st = st;
    e.mr = mr;
    return e;
  endfunction

  // A memory-wait phase of w stall cycles: either w idle cycles then ready,
  // or T idle cycles and then the fault state.
  function automatic ent_q_t wait_phase(input logic [3:0] st, input int w);
    ent_q_t r;
    for (int k = 0; k < w && k < T; k++) r.push_back(mk(st, 1'b0));
    if (w >= T) r.push_back(mk(4'd12, 1'($urandom)));
    else        r.push_back(mk(st, 1'b1));
    return r;
  endfunction

  function automatic ent_q_t build(input logic [5:0] op, input int wf, input int wm);
    ent_q_t q;
    ent_q_t r;
    q = wait_phase(4'd0, wf);
    if (q[q.size()-1].st == 4'd12) return q;
    q.push_back(mk(4'd1, 1'($urandom)));
    case (op)
      6'h00: begin q.push_back(mk(4'd6, 1'($urandom))); q.push_back(mk(4'd7, 1'($urandom))); end
      6'h23: begin
        q.push_back(mk(4'd2, 1'($urandom)));
        r = wait_phase(4'd3, wm);
        foreach (r[k]) q.push_back(r[k]);
        if (q[q.size()-1].st != 4'd12) q.push_back(mk(4'd4, 1'($urandom)));
      end
      6'h2B: begin
        q.push_back(mk(4'd2, 1'($urandom)));
        r = wait_phase(4'd5, wm);
        foreach (r[k]) q.push_back(r[k]);
      end
      6'h04, 6'h05: q.push_back(mk(4'd8, 1'($urandom)));
      6'h02:        q.push_back(mk(4'd9, 1'($urandom)));
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        q.push_back(mk(4'd10, 1'($urandom))); q.push_back(mk(4'd11, 1'($urandom)));
      end
      default:      q.push_back(mk(4'd12, 1'($urandom)));
    endcase
    return q;
  endfunction

  // ---------------- single compare process ----------------
  always @(negedge CLK) begin
    #2;
    if (chk_en) begin
      n_tests++;
      if (((dut_vec ^ exp_vec) & exp_mask) != '0) begin
        n_fail++;
        $display("FAIL cycle t=%0t state got %0d required %0d, outputs got %h required %h (mask %h)",
                 $time, State, exp_vec[3:0], dut_vec, exp_vec, exp_mask);
      end
      if (rec_en) obs.push_back(dut_vec);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] st, input logic [5:0] op, input logic mr, input int z);
    @(negedge CLK);
    Reset_L  = 1'b1;
    Opcode   = op;
    MemReady = mr;
    Zero     = (z < 0) ? 1'($urandom) : 1'(z);
    exp_vec  = model(st, op, Zero, mr);
    exp_mask = '1;
    chk_en   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset_L  = 1'b0;
    Opcode   = 6'($urandom);
    MemReady = 1'($urandom);
    Zero     = 1'($urandom);
    exp_vec  = '0;
    exp_mask = rst_mask;
    chk_en   = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      @(negedge CLK);
      Opcode   = 6'($urandom);
      MemReady = 1'($urandom);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int z,
                           input int abort_at, output bit faulted);
    ent_q_t q;
    bit aborted;
    q = build(op, wf, wm);
    faulted = (q[q.size()-1].st == 4'd12);
    aborted = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin aborted = 1'b1; break; end
      drive(q[i].st, (q[i].st == 4'd0) ? 6'($urandom) : op, q[i].mr, z);
    end
    if (aborted) begin
      do_reset();
      faulted = 1'b0;
    end
  endtask

  task automatic fault_cycles(input int n);
    repeat (n) drive(4'd12, 6'($urandom), 1'($urandom), -1);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic rec_start();
    #3;
    obs.delete();
    rec_en = 1'b1;
  endtask

  task automatic rec_stop();
    #3;
    rec_en = 1'b0;
  endtask

  // State i of the recorded run is expected in seq[4*i +: 4].
  task automatic check_seq(input string name, input int n, input logic [63:0] seq);
    logic [22:0] v;
    lit({name, "_len"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) begin
      v = obs[i];
      lit({name, "_state"}, {28'd0, v[3:0]}, {28'd0, seq[4*i +: 4]});
    end
  endtask

  function automatic logic [22:0] obs_at(input int i);
    return (i < obs.size()) ? obs[i] : 23'h7FFFFF;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit f;
    logic [22:0] v;
    int abort_at;
    int wf, wm;
    logic [5:0] op;
    logic [5:0] legal_ops [14];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                  6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rst_mask = '0;
    rst_mask[22] = 1'b1; rst_mask[20] = 1'b1; rst_mask[19] = 1'b1;
    rst_mask[18] = 1'b1; rst_mask[15] = 1'b1; rst_mask[4]  = 1'b1;
    rst_mask[3:0] = 4'hF;

    do_reset();

    // ADD, zero-wait
    rec_start(); run_instr(6'h00, 0, 0, -1, -1, f); rec_stop();
    check_seq("add_seq", 4, 64'h7610);
    v = obs_at(3);
    lit("add_rtwb_regwrite", {31'd0, v[15]}, 1);
    lit("add_rtwb_regdst",   {31'd0, v[17]}, 1);
    lit("add_rtwb_aluop",    {28'd0, v[8:5]}, 4'hF);
    v = obs_at(2);
    lit("add_rtexec_regwrite", {31'd0, v[15]}, 0);

    // LW with three stall cycles in MEMRD
    rec_start(); run_instr(6'h23, 0, 3, -1, -1, f); rec_stop();
    check_seq("lw_seq", 8, 64'h4333_3210);
    v = obs_at(7);
    lit("lw_memwb_memtoreg", {31'd0, v[16]}, 1);
    lit("lw_memwb_fault",    {31'd0, v[4]}, 0);

    // BEQ then BNE with Zero=0
    rec_start(); run_instr(6'h04, 0, 0, 0, -1, f); rec_stop();
    v = obs_at(2);
    lit("beq_pcwrite",  {31'd0, v[22]}, 0);
    lit("beq_pcsource", {30'd0, v[11:10]}, 1);
    rec_start(); run_instr(6'h05, 0, 0, 0, -1, f); rec_stop();
    v = obs_at(2);
    lit("bne_pcwrite",  {31'd0, v[22]}, 1);
    lit("bne_pcsource", {30'd0, v[11:10]}, 1);

    // SLTIU then ADDI in IWB
    rec_start(); run_instr(6'h0B, 0, 0, -1, -1, f); rec_stop();
    v = obs_at(3);
    lit("sltiu_iwb_aluop", {28'd0, v[8:5]}, 4'b1011);
    lit("sltiu_iwb_sext",  {31'd0, v[9]}, 0);
    rec_start(); run_instr(6'h08, 0, 0, -1, -1, f); rec_stop();
    v = obs_at(3);
    lit("addi_iwb_aluop", {28'd0, v[8:5]}, 4'b0010);
    lit("addi_iwb_sext",  {31'd0, v[9]}, 1);

    // Illegal opcode: sticky fault for 100 cycles, cleared only by reset
    rec_start(); run_instr(6'h3F, 0, 0, -1, -1, f); rec_stop();
    check_seq("illegal_seq", 3, 64'hC10);
    fault_cycles(100);
    #3;
    lit("fault_after_100", {31'd0, Fault}, 1);
    do_reset();
    #3;
    lit("fault_in_reset", {31'd0, Fault}, 0);

    // Watchdog: four idle FETCH cycles fault, ready on the fourth does not
    rec_start(); run_instr(6'h00, 4, 0, -1, -1, f); rec_stop();
    check_seq("timeout_seq", 5, 64'hC_0000);
    fault_cycles(3);
    do_reset();
    rec_start(); run_instr(6'h02, 3, 0, -1, -1, f); rec_stop();
    check_seq("ready_at_limit_seq", 6, 64'h91_0000);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      else                            op = legal_ops[$urandom_range(0, 13)];
      wf = ($urandom_range(0, 11) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T-1);
      wm = ($urandom_range(0, 11) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T-1);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : -1;
      run_instr(op, wf, wm, -1, abort_at, f);
      if (f) begin
        fault_cycles($urandom_range(1, 5));
        do_reset();
      end
    end

    #3;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
`default_nettype wire
